regfile_port_arbiter: RTL and testbench

- Sits between decode/operand-fetch, the writeback stage and the 8x16 register file.
- Shares the register file's single read/write port 1 between operand reads and writebacks; port 2 is read-only.
- Keeps a per-register busy scoreboard to block RAW/WAW hazards.
- Returns operand data one cycle after acceptance.
- Bounds writeback priority so operand fetch cannot starve.

---
 rtl/anna_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 56 +++++
 rtl/regfile_port_arbiter.sv | 126 ++++++++++++
 tb/tb_regfile_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anna_pkg.sv
// Shared register-file types and sizes for the operand/writeback datapath.
package anna_pkg;

  localparam int WORD_SIZE    = 16;
  localparam int REG_COUNT    = 8;
  localparam int ADDR_SIZE    = $clog2(REG_COUNT);
  localparam int MAX_WB_BURST = 4;

  typedef logic [ADDR_SIZE-1:0] reg_addr_t;
  typedef logic [WORD_SIZE-1:0] word_t;

  // r0 is hardwired to zero and is never tracked as busy.
  localparam reg_addr_t REG_ZERO = '0;

  function automatic logic is_reg_zero(input reg_addr_t idx);
    return idx == REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy vector: set on issue of a writing op, cleared on
// writeback, wiped on flush. Answers RAW/WAW hazard queries combinationally.
module regfile_scoreboard
  import anna_pkg::*;
#(
  parameter int REG_COUNT = anna_pkg::REG_COUNT,
  parameter int ADDR_SIZE = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 set_en,
  input  logic [ADDR_SIZE-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [ADDR_SIZE-1:0] clr_idx,
  input  logic [ADDR_SIZE-1:0] q_rs1,
  input  logic                 q_use_rs1,
  input  logic [ADDR_SIZE-1:0] q_rs2,
  input  logic                 q_use_rs2,
  input  logic [ADDR_SIZE-1:0] q_rd,
  input  logic                 q_writes_rd,
  output logic                 hazard,
  output logic [REG_COUNT-1:0] busy
);

  logic [REG_COUNT-1:0] busy_next;

  assign hazard = (q_use_rs1 & busy[q_rs1])
                | (q_use_rs2 & busy[q_rs2])
                | (q_writes_rd & (q_rd != '0) & busy[q_rd]);

  // Next busy vector: clear first, then set, so a same-index set wins; r0 stays clear.
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_idx] = 1'b0;
    if (set_en) busy_next[set_idx] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Busy register with flush taking precedence over set/clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      busy <= '0;
    else if (flush) busy <= '0;
    else            busy <= busy_next;
  end

`ifndef SYNTHESIS
  // A set and clear on the same register means a WAW slipped past the hazard check.
  always @(posedge clk) begin
    if (!reset && !flush && set_en && clr_en)
      assert (set_idx != clr_idx)
        else $error("scoreboard set and clear hit register %0d in the same cycle", set_idx);
  end
`endif

endmodule

// File: rtl/regfile_port_arbiter.sv
// Arbitrates the shared read/write port 1 of the register file between
// operand fetch and writeback, with a bounded writeback burst so a
// hazard-free operand request cannot starve. Port 2 is read-only.
module regfile_port_arbiter
  import anna_pkg::*;
#(
  parameter int REG_COUNT    = anna_pkg::REG_COUNT,
  parameter int ADDR_SIZE    = $clog2(REG_COUNT),
  parameter int WORD_SIZE    = anna_pkg::WORD_SIZE,
  parameter int MAX_WB_BURST = anna_pkg::MAX_WB_BURST
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [ADDR_SIZE-1:0] op_rs1,
  input  logic [ADDR_SIZE-1:0] op_rs2,
  input  logic                 op_use_rs1,
  input  logic                 op_use_rs2,
  input  logic [ADDR_SIZE-1:0] op_rd,
  input  logic                 op_writes_rd,
  output logic                 opr_valid,
  output logic [WORD_SIZE-1:0] opr_data1,
  output logic [WORD_SIZE-1:0] opr_data2,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic [ADDR_SIZE-1:0] wb_rd,
  input  logic [WORD_SIZE-1:0] wb_data,
  input  logic                 flush,
  output logic                 rf_r_en1,
  output logic                 rf_r_en2,
  output logic                 rf_w_en,
  output logic [ADDR_SIZE-1:0] rf_reg1,
  output logic [ADDR_SIZE-1:0] rf_reg2,
  output logic [WORD_SIZE-1:0] rf_w_data,
  input  logic [WORD_SIZE-1:0] rf_r_data1,
  input  logic [WORD_SIZE-1:0] rf_r_data2
);

  localparam int STARVE_W = $clog2(MAX_WB_BURST + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_WB_BURST);

  logic                 hazard;
  logic [REG_COUNT-1:0] busy;
  logic                 conflict;
  logic                 op_wins;
  logic                 op_accept;
  logic                 wb_accept;
  logic [STARVE_W-1:0]  starve_cnt;
  logic                 use1_q;
  logic                 use2_q;

  regfile_scoreboard #(
    .REG_COUNT (REG_COUNT),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .set_en      (op_accept & op_writes_rd & (op_rd != '0)),
    .set_idx     (op_rd),
    .clr_en      (wb_accept & (wb_rd != '0)),
    .clr_idx     (wb_rd),
    .q_rs1       (op_rs1),
    .q_use_rs1   (op_use_rs1),
    .q_rs2       (op_rs2),
    .q_use_rs2   (op_use_rs2),
    .q_rd        (op_rd),
    .q_writes_rd (op_writes_rd),
    .hazard      (hazard),
    .busy        (busy)
  );

  // Port 1 is contested only by a hazard-free op that needs rs1 while a writeback waits.
  assign conflict  = op_valid & op_use_rs1 & ~hazard & wb_valid;
  assign op_wins   = conflict & ~flush & (starve_cnt == STARVE_MAX);
  assign op_ready  = ~reset & ~hazard & ~flush & (~op_use_rs1 | ~wb_valid | op_wins);
  assign wb_ready  = ~reset & ~op_wins;
  assign op_accept = op_valid & op_ready;
  assign wb_accept = wb_valid & wb_ready;

  // A read on port 1 and a write never coincide, so the port mux keys off the write.
  assign rf_w_en   = wb_accept;
  assign rf_w_data = wb_data;
  assign rf_r_en1  = op_accept & op_use_rs1;
  assign rf_r_en2  = op_accept & op_use_rs2;
  assign rf_reg1   = wb_accept ? wb_rd : op_rs1;
  assign rf_reg2   = op_rs2;

  // Response data arrives from the register file one cycle after the read.
  assign opr_data1 = use1_q ? rf_r_data1 : '0;
  assign opr_data2 = use2_q ? rf_r_data2 : '0;

  // Count consecutive writeback wins over a waiting op, saturating at the burst limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      starve_cnt <= '0;
    else if (op_accept || !conflict)
      starve_cnt <= '0;
    else if (starve_cnt != STARVE_MAX)
      starve_cnt <= starve_cnt + STARVE_W'(1);
  end

  // Remember what the accepted op asked for so the next cycle can return it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opr_valid <= 1'b0;
      use1_q    <= 1'b0;
      use2_q    <= 1'b0;
    end else begin
      opr_valid <= op_accept;
      use1_q    <= op_accept & op_use_rs1;
      use2_q    <= op_accept & op_use_rs2;
    end
  end

`ifndef SYNTHESIS
  // A writeback to a register nobody reserved points at a broken pipeline upstream.
  always @(posedge clk) begin
    if (!reset && wb_accept && (wb_rd != '0))
      assert (busy[wb_rd])
        else $error("writeback to non-busy register %0d", wb_rd);
  end
`endif

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a small register-file model.
module tb_regfile_port_arbiter;
  import anna_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  logic      op_valid, op_ready, op_use_rs1, op_use_rs2, op_writes_rd;
  reg_addr_t op_rs1, op_rs2, op_rd;
  logic      opr_valid;
  word_t     opr_data1, opr_data2;
  logic      wb_valid, wb_ready;
  reg_addr_t wb_rd;
  word_t     wb_data;
  logic      flush;
  logic      rf_r_en1, rf_r_en2, rf_w_en;
  reg_addr_t rf_reg1, rf_reg2;
  word_t     rf_w_data, rf_r_data1, rf_r_data2;

  int vectors     = 0;
  int miscompares = 0;

  word_t     mem [REG_COUNT];
  reg_addr_t wb_q [6];
  logic      exp_wb [7];
  logic      exp_op [7];
  int        k;
  logic      op_pending;

  regfile_port_arbiter dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_rs1(op_rs1), .op_rs2(op_rs2),
    .op_use_rs1(op_use_rs1), .op_use_rs2(op_use_rs2), .op_rd(op_rd),
    .op_writes_rd(op_writes_rd),
    .opr_valid(opr_valid), .opr_data1(opr_data1), .opr_data2(opr_data2),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .rf_r_en1(rf_r_en1), .rf_r_en2(rf_r_en2), .rf_w_en(rf_w_en),
    .rf_reg1(rf_reg1), .rf_reg2(rf_reg2), .rf_w_data(rf_w_data),
    .rf_r_data1(rf_r_data1), .rf_r_data2(rf_r_data2)
  );

  always #5 clk = ~clk;

  // Register file model: synchronous reset, 1-cycle read latency, r0 drops writes.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) mem[i] <= '0;
      rf_r_data1 <= '0;
      rf_r_data2 <= '0;
    end else begin
      if (rf_w_en && rf_reg1 != '0) mem[rf_reg1] <= rf_w_data;
      if (rf_r_en1) rf_r_data1 <= (rf_reg1 == '0) ? '0 : mem[rf_reg1];
      if (rf_r_en2) rf_r_data2 <= (rf_reg2 == '0) ? '0 : mem[rf_reg2];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic v, input reg_addr_t rs1, input reg_addr_t rs2,
                          input logic u1, input logic u2, input reg_addr_t rd, input logic wr);
    op_valid = v; op_rs1 = rs1; op_rs2 = rs2;
    op_use_rs1 = u1; op_use_rs2 = u2; op_rd = rd; op_writes_rd = wr;
  endtask

  task automatic drive_wb(input logic v, input reg_addr_t rd, input word_t data);
    wb_valid = v; wb_rd = rd; wb_data = data;
  endtask

  task automatic idle();
    drive_op(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    drive_wb(1'b0, 0, 16'h0000);
    flush = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  // Linear sequence of directed steps with hand-computed expectations.
  initial begin
    wb_q   = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
    exp_wb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_op = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset with requests presented: nothing may be granted or enabled.
    reset = 1'b1;
    idle();
    drive_op(1'b1, 1, 2, 1'b1, 1'b1, 0, 1'b0);
    drive_wb(1'b1, 3, 16'h1111);
    #1;
    check("rst_op_ready", op_ready, 0);
    check("rst_wb_ready", wb_ready, 0);
    check("rst_rf_w_en", rf_w_en, 0);
    check("rst_rf_r_en1", rf_r_en1, 0);
    check("rst_opr_valid", opr_valid, 0);
    tick();
    tick();
    reset = 1'b0;
    idle();
    #1;
    check("post_rst_opr_valid", opr_valid, 0);
    check("post_rst_opr_data1", opr_data1, 0);

    // Reserve r3 and r5, write them back, then read both.
    drive_op(1'b1, 0, 0, 1'b0, 1'b0, 3, 1'b1);
    #1; check("t1_res3_ready", op_ready, 1);
    tick();
    drive_op(1'b1, 0, 0, 1'b0, 1'b0, 5, 1'b1);
    #1; check("t1_res5_ready", op_ready, 1);
    check("t1_nouse_resp_valid", opr_valid, 1);
    check("t1_nouse_resp_data1", opr_data1, 0);
    tick();
    idle();
    drive_wb(1'b1, 3, 16'h1234);
    #1;
    check("t1_wb3_ready", wb_ready, 1);
    check("t1_wb3_rf_w_en", rf_w_en, 1);
    check("t1_wb3_rf_reg1", rf_reg1, 3);
    check("t1_wb3_rf_w_data", rf_w_data, 16'h1234);
    tick();
    drive_wb(1'b1, 5, 16'hBEEF);
    #1; check("t1_wb5_ready", wb_ready, 1);
    tick();
    idle();
    drive_op(1'b1, 3, 5, 1'b1, 1'b1, 0, 1'b0);
    #1;
    check("t1_rd_ready", op_ready, 1);
    check("t1_rd_rf_r_en1", rf_r_en1, 1);
    check("t1_rd_rf_reg1", rf_reg1, 3);
    check("t1_rd_rf_r_en2", rf_r_en2, 1);
    check("t1_rd_rf_reg2", rf_reg2, 5);
    tick();
    idle();
    #1;
    check("t1_resp_valid", opr_valid, 1);
    check("t1_resp_data1", opr_data1, 16'h1234);
    check("t1_resp_data2", opr_data2, 16'hBEEF);
    tick();
    check("t1_resp_pulse_end", opr_valid, 0);

    // RAW stall on r2 until its writeback lands.
    drive_op(1'b1, 0, 0, 1'b0, 1'b0, 2, 1'b1);
    #1; check("t2_res2_ready", op_ready, 1);
    tick();
    drive_op(1'b1, 2, 0, 1'b1, 1'b0, 0, 1'b0);
    #1; check("t2_raw_stall_a", op_ready, 0);
    tick();
    #1; check("t2_raw_stall_b", op_ready, 0);
    drive_wb(1'b1, 2, 16'h00AA);
    #1;
    check("t2_raw_stall_wb_cycle", op_ready, 0);
    check("t2_wb2_ready", wb_ready, 1);
    tick();
    drive_wb(1'b0, 0, 16'h0000);
    #1; check("t2_raw_release", op_ready, 1);
    tick();
    idle();
    #1;
    check("t2_resp_valid", opr_valid, 1);
    check("t2_resp_data1", opr_data1, 16'h00AA);

    // Reserve six registers back to back, then contend a writeback burst with an op.
    foreach (wb_q[i]) begin
      drive_op(1'b1, 0, 0, 1'b0, 1'b0, wb_q[i], 1'b1);
      #1; check("t3_reserve_ready", op_ready, 1);
      tick();
    end
    k = 0;
    op_pending = 1'b1;
    for (int c = 0; c < 7; c++) begin
      drive_wb(1'b1, wb_q[k], 16'h1000 | 16'(wb_q[k]));
      if (op_pending) drive_op(1'b1, 3, 0, 1'b1, 1'b0, 0, 1'b0);
      else            drive_op(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
      #1;
      check($sformatf("t3_wb_ready_c%0d", c), wb_ready, exp_wb[c]);
      if (op_pending) check($sformatf("t3_op_ready_c%0d", c), op_ready, exp_op[c]);
      if (c == 4) begin
        check("t3_opwin_rf_w_en", rf_w_en, 0);
        check("t3_opwin_rf_r_en1", rf_r_en1, 1);
        check("t3_opwin_rf_reg1", rf_reg1, 3);
      end
      if (c == 5) begin
        check("t3_resp_valid", opr_valid, 1);
        check("t3_resp_data1", opr_data1, 16'h1234);
        check("t3_after_win_rf_reg1", rf_reg1, 6);
      end
      if (exp_wb[c]) k++;
      if (exp_op[c]) op_pending = 1'b0;
      tick();
    end
    idle();

    // Dual issue: rs2-only op alongside a writeback to r1.
    drive_op(1'b1, 0, 0, 1'b0, 1'b0, 1, 1'b1);
    #1; check("t4_res1_ready", op_ready, 1);
    tick();
    drive_op(1'b1, 0, 7, 1'b0, 1'b1, 0, 1'b0);
    drive_wb(1'b1, 1, 16'h5555);
    #1;
    check("t4_dual_op_ready", op_ready, 1);
    check("t4_dual_wb_ready", wb_ready, 1);
    check("t4_dual_rf_w_en", rf_w_en, 1);
    check("t4_dual_rf_reg1", rf_reg1, 1);
    check("t4_dual_rf_r_en1", rf_r_en1, 0);
    check("t4_dual_rf_r_en2", rf_r_en2, 1);
    check("t4_dual_rf_reg2", rf_reg2, 7);
    tick();
    idle();
    drive_op(1'b1, 1, 0, 1'b1, 1'b0, 0, 1'b0);
    #1;
    check("t4_resp_valid", opr_valid, 1);
    check("t4_resp_data1_unused", opr_data1, 0);
    check("t4_resp_data2", opr_data2, 16'h1007);
    tick();
    idle();
    #1; check("t4_r1_written", opr_data1, 16'h5555);

    // Flush clears the r4 reservation and blocks the op for that cycle only.
    drive_op(1'b1, 0, 0, 1'b0, 1'b0, 4, 1'b1);
    #1; check("t5_res4_ready", op_ready, 1);
    tick();
    drive_op(1'b1, 4, 0, 1'b1, 1'b0, 0, 1'b0);
    flush = 1'b1;
    #1;
    check("t5_flush_blocks_op", op_ready, 0);
    check("t5_flush_inflight_resp", opr_valid, 1);
    tick();
    flush = 1'b0;
    #1; check("t5_after_flush_ready", op_ready, 1);
    tick();
    idle();
    drive_wb(1'b1, 0, 16'hFFFF);
    #1;
    check("t5_resp_valid", opr_valid, 1);
    check("t5_resp_data1", opr_data1, 16'h1004);
    check("t5_wb_r0_ready", wb_ready, 1);
    check("t5_wb_r0_rf_w_en", rf_w_en, 1);
    check("t5_wb_r0_rf_reg1", rf_reg1, 0);
    tick();
    idle();
    drive_op(1'b1, 0, 0, 1'b1, 1'b1, 0, 1'b0);
    #1; check("t5_r0_read_ready", op_ready, 1);
    tick();
    idle();
    #1;
    check("t5_r0_data1", opr_data1, 0);
    check("t5_r0_data2", opr_data2, 0);

    // Reset right after an accept: response dropped, scoreboard wiped.
    drive_op(1'b1, 3, 0, 1'b1, 1'b0, 6, 1'b1);
    #1; check("t6_accept_ready", op_ready, 1);
    tick();
    reset = 1'b1;
    idle();
    #1;
    check("t6_rst_opr_valid", opr_valid, 0);
    check("t6_rst_op_ready", op_ready, 0);
    tick();
    reset = 1'b0;
    drive_op(1'b1, 6, 0, 1'b1, 1'b0, 6, 1'b1);
    #1;
    check("t6_release_opr_valid", opr_valid, 0);
    check("t6_release_op_ready", op_ready, 1);
    tick();
    idle();
    #1;
    check("t6_resp_valid", opr_valid, 1);
    check("t6_resp_data1", opr_data1, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
